rx_iq_buffer: RTL and testbench
===============================

# rx_iq_buffer

Single-clock first-word-fall-through FIFO between the RX DDC outputs and the STM32 bus interface. It pairs RX1 and RX2 I/Q samples into one entry per output sample period and presents the head entry on the interface's RX1_I/Q and RX2_I/Q inputs. It advances on the interface's IQ_RX_READ_CLK pulse and reports overrun, underrun and pairing errors.

## Interface
- ADDR_W, 9, log2 of FIFO depth (512 entries)
- WIDTH, 24, sample width, signed
- clk_in  in  1  system clock, same domain as the bus interface
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous flush: empties FIFO, drops pending halves; flags untouched
- rx2_en  in  1  1 = entries carry RX1+RX2; 0 = RX1 only, RX2 fields written as 0
- rx1_valid  in  1  one-cycle strobe, rx1_i/rx1_q valid
- rx1_i, rx1_q  in  WIDTH each  RX1 DDC sample
- rx2_valid  in  1  one-cycle strobe, rx2_i/rx2_q valid
- rx2_i, rx2_q  in  WIDTH each  RX2 DDC sample
- rd_req  in  1  read request level (IQ_RX_READ_REQ)
- rd_clk  in  1  read pulse (IQ_RX_READ_CLK); a pop is its rising edge while rd_req=1
- flags_clr  in  1  one-cycle strobe, clears overrun/underrun/pair_err
- RX1_I, RX1_Q, RX2_I, RX2_Q  out  WIDTH each  head entry, registered
- empty  out  1  no valid head on outputs
- level  out  ADDR_W+1  entries stored, head included
- overrun, underrun, pair_err  out  1 each  sticky flags

## Operation
- Pop detect: rd_clk_d registers rd_clk. pop = rd_clk & ~rd_clk_d & rd_req. rd_clk held high produces exactly one pop.
- Pairing, rx2_en=0: rx1_valid commits {rx1_i, rx1_q, 0, 0}. rx2_valid is ignored.
- Pairing, rx2_en=1:
  - Per-channel holding registers with pending bits p1/p2.
  - An entry commits in the cycle both halves are available. Simultaneous valids commit directly. Otherwise the commit happens when the second valid arrives.
  - A valid on an already-pending channel overwrites that half and sets pair_err.
  - Changing rx2_en clears p1/p2.
- Commit when full (level = 2^ADDR_W) with no pop in the same cycle: the entry is dropped and overrun is set.
- Commit and pop in the same cycle while full: both are accepted; level is unchanged.
- Pop while empty=1: ignored, underrun set, outputs stay 0.
- Head register model:
  - Memory plus one output register stage.
  - Outputs show the oldest entry whenever empty=0.
  - A pop loads the next entry, or zeros with empty=1 if none remains.
- Wrap-around: read and write pointers are ADDR_W bits and wrap naturally. Full and empty are derived from level, not from pointer equality.
- flush: pointers, level and p1/p2 are cleared and outputs are zeroed; empty=1 the next cycle. flush wins over a simultaneous commit or pop. Flags are kept.
- flags_clr: clears all three flags. A flag event in the same cycle wins, so the flag stays set.
- Reset values (asynchronous): all RX outputs 0, empty=1, level=0, all flags 0, p1=p2=0, rd_clk_d=0, pointers 0.

## Timing
- Commit at edge E into an empty FIFO: level=1 after E. Outputs hold the entry and empty=0 after E+2.
- Pop at edge E: the interface samples the current head at E. Outputs present the next entry after E+1; level decrements after E.
- The interface's pop-to-sample spacing (six or twelve clk_in cycles) exceeds the 1-cycle head refill, so back-to-back pops never return a stale head.
- Pop at E with level=1 and a commit at E: empty=1 after E+1. The new entry is on the outputs after E+2.
- Flags and level update on the edge of the causing event.
- Pair completion adds no latency: the commit happens in the same cycle as the second valid.

## Test plan
- Reset, then pop with no data: outputs 0, empty=1, underrun=1. After flags_clr: underrun=0.
- rx2_en=0; write RX1 (I,Q) = (0x000001, 0xFFFFFF), then (0x7FFFFF, 0x800000). Each pop returns them in order with RX2 fields=0. The second pop leaves empty=1 and level=0.
- rx2_en=1; rx1_valid at cycle 0, rx2_valid at cycle 3, then both valid together at cycle 10 → two entries with correct pairing. A second rx1_valid before rx2 sets pair_err and the later value is used.
- Fill to 512 entries, commit once more: level stays 512, overrun=1, the dropped entry never appears. Then pop and commit in the same cycle: level stays 512, the order is preserved across pointer wrap.
- Hold rd_clk high for 5 cycles with rd_req=1 → exactly one pop (level decrements by 1). rd_clk rising with rd_req=0 → no pop.
- Mid-stream flush with level=37: empty=1 and level=0 next cycle, flags unchanged. Assert reset_n low mid-pop: all outputs go to reset values immediately (asynchronous).

Source files
------------

// File: rtl/rx_iq_buffer.sv
// rx_iq_buffer: pairs RX1/RX2 DDC samples into entries and buffers them in a first-word-fall-through FIFO for the bus interface
module rx_iq_buffer #(
    parameter int ADDR_W = 9,
    parameter int WIDTH  = 24
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              rx2_en,
    input  logic              rx1_valid,
    input  logic [WIDTH-1:0]  rx1_i,
    input  logic [WIDTH-1:0]  rx1_q,
    input  logic              rx2_valid,
    input  logic [WIDTH-1:0]  rx2_i,
    input  logic [WIDTH-1:0]  rx2_q,
    input  logic              rd_req,
    input  logic              rd_clk,
    input  logic              flags_clr,
    output logic [WIDTH-1:0]  RX1_I,
    output logic [WIDTH-1:0]  RX1_Q,
    output logic [WIDTH-1:0]  RX2_I,
    output logic [WIDTH-1:0]  RX2_Q,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overrun,
    output logic              underrun,
    output logic              pair_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int EW    = 4 * WIDTH;

    logic [EW-1:0]      mem [DEPTH];
    logic [EW-1:0]      rd_data_q;
    logic [EW-1:0]      head_q, head_d, wdata;
    logic [2*WIDTH-1:0] h1_q, h1_d, h2_q, h2_d;
    logic [ADDR_W-1:0]  wp_q, wp_d, rp_q, rp_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic               rd_clk_q, en_q;
    logic               p1_q, p1_d, p2_q, p2_d;
    logic               hv_q, hv_d, rv_q, rv_d;
    logic               ov_q, ov_d, un_q, un_d, pe_q, pe_d;
    logic               chg, p1e, p2e, n1, n2, commit, perr_ev;
    logic               pop_req, pop, load, full, wr;

    // Pairing: hold each half until its partner arrives; a mode change drops pending halves
    always_comb begin
        chg     = rx2_en ^ en_q;
        p1e     = p1_q & ~chg;
        p2e     = p2_q & ~chg;
        n1      = rx1_valid | p1e;
        n2      = rx2_valid | p2e;
        h1_d    = rx1_valid ? {rx1_i, rx1_q} : h1_q;
        h2_d    = rx2_valid ? {rx2_i, rx2_q} : h2_q;
        commit  = ~flush & (rx2_en ? (n1 & n2) : rx1_valid);
        wdata   = {h1_d, rx2_en ? h2_d : {2*WIDTH{1'b0}}};
        p1_d    = ~flush & rx2_en & n1 & ~(n1 & n2);
        p2_d    = ~flush & rx2_en & n2 & ~(n1 & n2);
        perr_ev = ~flush & rx2_en & ((rx1_valid & p1e) | (rx2_valid & p2e));
    end

    // FIFO control: head register refills from the registered memory read one cycle after it empties
    always_comb begin
        pop_req = rd_clk & ~rd_clk_q & rd_req & ~flush;
        pop     = pop_req & hv_q;
        load    = ~hv_q & rv_q;
        full    = level == (ADDR_W+1)'(DEPTH);
        wr      = commit & (~full | pop);
        rp_d    = flush ? '0 : rp_q + ADDR_W'(load);
        wp_d    = flush ? '0 : wp_q + ADDR_W'(wr);
        cnt_d   = flush ? '0 : cnt_q + (ADDR_W+1)'(wr) - (ADDR_W+1)'(load);
        hv_d    = ~flush & (load | (hv_q & ~pop));
        head_d  = (flush | pop) ? '0 : (load ? rd_data_q : head_q);
        rv_d    = ~flush & (cnt_q != (ADDR_W+1)'(load));
        ov_d    = (ov_q & ~flags_clr) | (commit & full & ~pop);
        un_d    = (un_q & ~flags_clr) | (pop_req & ~hv_q);
        pe_d    = (pe_q & ~flags_clr) | perr_ev;
    end

    // Control and output state, asynchronously reset
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rd_clk_q <= 1'b0;
            en_q     <= 1'b0;
            p1_q     <= 1'b0;
            p2_q     <= 1'b0;
            h1_q     <= '0;
            h2_q     <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            hv_q     <= 1'b0;
            rv_q     <= 1'b0;
            head_q   <= '0;
            ov_q     <= 1'b0;
            un_q     <= 1'b0;
            pe_q     <= 1'b0;
        end else begin
            rd_clk_q <= rd_clk;
            en_q     <= rx2_en;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            h1_q     <= h1_d;
            h2_q     <= h2_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            hv_q     <= hv_d;
            rv_q     <= rv_d;
            head_q   <= head_d;
            ov_q     <= ov_d;
            un_q     <= un_d;
            pe_q     <= pe_d;
        end
    end

    // Sample memory with synchronous read of the next entry to move into the head
    always_ff @(posedge clk_in) begin
        if (wr) mem[wp_q] <= wdata;
        rd_data_q <= mem[rp_d];
    end

    assign {RX1_I, RX1_Q, RX2_I, RX2_Q} = head_q;
    assign empty    = ~hv_q;
    assign level    = cnt_q + (ADDR_W+1)'(hv_q);
    assign overrun  = ov_q;
    assign underrun = un_q;
    assign pair_err = pe_q;
endmodule

// File: tb/tb_rx_iq_buffer.sv
// tb_rx_iq_buffer: random and directed stimulus against a queue-based reference model of rx_iq_buffer
module tb_rx_iq_buffer;
    localparam int AW = 9, W = 24, DEPTH = 512;

    logic clk_in = 0, reset_n = 0, flush = 0, rx2_en = 0, rx1_valid = 0, rx2_valid = 0;
    logic rd_req = 0, rd_clk = 0, flags_clr = 0;
    logic [W-1:0] rx1_i = 0, rx1_q = 0, rx2_i = 0, rx2_q = 0;
    logic [W-1:0] RX1_I, RX1_Q, RX2_I, RX2_Q;
    logic empty, overrun, underrun, pair_err;
    logic [AW:0] level;
    int total = 0, bad = 0;

    always #5 clk_in = ~clk_in;

    rx_iq_buffer #(.ADDR_W(AW), .WIDTH(W)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .flush(flush), .rx2_en(rx2_en),
        .rx1_valid(rx1_valid), .rx1_i(rx1_i), .rx1_q(rx1_q),
        .rx2_valid(rx2_valid), .rx2_i(rx2_i), .rx2_q(rx2_q),
        .rd_req(rd_req), .rd_clk(rd_clk), .flags_clr(flags_clr),
        .RX1_I(RX1_I), .RX1_Q(RX1_Q), .RX2_I(RX2_I), .RX2_Q(RX2_Q),
        .empty(empty), .level(level), .overrun(overrun), .underrun(underrun), .pair_err(pair_err)
    );

    // Reference state: queue of stored entries with the edge each was committed on
    typedef struct { logic [4*W-1:0] d; int t; } ent_t;
    ent_t mq[$];
    int k = 0, fr = 0;
    logic m_en = 0, m_p1 = 0, m_p2 = 0, m_prev = 0, m_ov = 0, m_un = 0, m_pe = 0;
    logic [2*W-1:0] m_h1 = 0, m_h2 = 0;

    task automatic chk(input string tag, input logic [4*W-1:0] got, input logic [4*W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Head is visible two edges after its commit, or one edge after the pop that exposed it
    task automatic model();
        logic com, pv, pr, ov, un, pe;
        logic [4*W-1:0] cd;
        com = 0; ov = 0; un = 0; pe = 0; cd = '0;
        k++;
        pr = rd_clk && !m_prev && rd_req;
        m_prev = rd_clk;
        if (rx2_en != m_en) begin m_p1 = 0; m_p2 = 0; end
        m_en = rx2_en;
        if (flush) begin
            mq.delete(); m_p1 = 0; m_p2 = 0;
        end else begin
            if (!rx2_en) begin
                com = rx1_valid; cd = {rx1_i, rx1_q, {2*W{1'b0}}};
            end else begin
                if (rx1_valid) begin pe |= m_p1; m_h1 = {rx1_i, rx1_q}; m_p1 = 1; end
                if (rx2_valid) begin pe |= m_p2; m_h2 = {rx2_i, rx2_q}; m_p2 = 1; end
                if (m_p1 && m_p2) begin com = 1; cd = {m_h1, m_h2}; m_p1 = 0; m_p2 = 0; end
            end
            pv = mq.size() > 0 && k > fr;
            un = pr && !pv;
            if (pr && pv) begin
                void'(mq.pop_front());
                if (mq.size() > 0) fr = (mq[0].t + 2 > k + 1) ? mq[0].t + 2 : k + 1;
            end
            if (com) begin
                if (mq.size() < DEPTH) begin
                    if (mq.size() == 0) fr = k + 2;
                    mq.push_back('{cd, k});
                end else ov = 1;
            end
        end
        m_ov = (m_ov && !flags_clr) || ov;
        m_un = (m_un && !flags_clr) || un;
        m_pe = (m_pe && !flags_clr) || pe;
    endtask

    task automatic check_all();
        logic ee;
        logic [4*W-1:0] eh;
        ee = !(mq.size() > 0 && k >= fr);
        eh = ee ? '0 : mq[0].d;
        chk("level", 96'(level), 96'(mq.size()));
        chk("empty", 96'(empty), 96'(ee));
        chk("head", {RX1_I, RX1_Q, RX2_I, RX2_Q}, eh);
        chk("overrun", 96'(overrun), 96'(m_ov));
        chk("underrun", 96'(underrun), 96'(m_un));
        chk("pair_err", 96'(pair_err), 96'(m_pe));
    endtask

    task automatic step();
        @(posedge clk_in);
        model();
        #1;
        check_all();
        rx1_valid = 0; rx2_valid = 0; flags_clr = 0; flush = 0;
    endtask

    task automatic pop_pulse(input int gap);
        rd_req = 1; rd_clk = 1;
        step();
        rd_clk = 0;
        repeat (gap - 1) step();
    endtask

    task automatic wr1(input logic [W-1:0] i, input logic [W-1:0] q);
        rx1_valid = 1; rx1_i = i; rx1_q = q;
        step();
    endtask

    initial begin
        int lv, gap;
        logic sv_ov, sv_un, sv_pe;
        #12 reset_n = 1;
        check_all();

        pop_pulse(3);
        chk("underrun_set", 96'(underrun), 96'(1));
        chk("underrun_head", {RX1_I, RX1_Q, RX2_I, RX2_Q}, 96'(0));
        flags_clr = 1; step();
        chk("underrun_clr", 96'(underrun), 96'(0));

        rx2_en = 0; step();
        wr1(24'h000001, 24'hFFFFFF);
        wr1(24'h7FFFFF, 24'h800000);
        repeat (3) step();
        chk("first_head", {RX1_I, RX1_Q, RX2_I, RX2_Q}, {24'h000001, 24'hFFFFFF, 48'h0});
        pop_pulse(6);
        chk("second_head", {RX1_I, RX1_Q, RX2_I, RX2_Q}, {24'h7FFFFF, 24'h800000, 48'h0});
        pop_pulse(6);
        chk("drained_level", 96'(level), 96'(0));
        chk("drained_empty", 96'(empty), 96'(1));

        rx2_en = 1; step();
        rx1_valid = 1; rx1_i = 24'h111111; rx1_q = 24'h222222; step();
        repeat (2) step();
        rx2_valid = 1; rx2_i = 24'h333333; rx2_q = 24'h444444; step();
        repeat (6) step();
        rx1_valid = 1; rx1_i = 24'h555555; rx1_q = 24'h666666;
        rx2_valid = 1; rx2_i = 24'h777777; rx2_q = 24'h888888; step();
        rx1_valid = 1; rx1_i = 24'hAAAAAA; rx1_q = 24'hBBBBBB; step();
        rx1_valid = 1; rx1_i = 24'hCCCCCC; rx1_q = 24'hDDDDDD; step();
        rx2_valid = 1; rx2_i = 24'hEEEEEE; rx2_q = 24'h123456; step();
        chk("pair_err_set", 96'(pair_err), 96'(1));
        chk("paired_level", 96'(level), 96'(3));
        repeat (3) pop_pulse(6);
        chk("paired_drained", 96'(level), 96'(0));

        flags_clr = 1; rx2_en = 0; step();
        for (int i = 0; i < DEPTH; i++) wr1(W'($urandom), W'($urandom));
        repeat (3) step();
        wr1(24'hDEAD00, 24'h00BEEF);
        chk("full_level", 96'(level), 96'(DEPTH));
        chk("overrun_set", 96'(overrun), 96'(1));
        rd_req = 1; rd_clk = 1; rx1_valid = 1; rx1_i = 24'h0F0F0F; rx1_q = 24'hF0F0F0; step();
        rd_clk = 0;
        chk("full_popcommit", 96'(level), 96'(DEPTH));
        for (int n = 0; n < DEPTH + 8 && mq.size() > 0; n++) pop_pulse(6);
        chk("wrap_drained", 96'(level), 96'(0));

        for (int i = 0; i < 4; i++) wr1(W'($urandom), W'($urandom));
        repeat (3) step();
        lv = mq.size();
        rd_req = 1; rd_clk = 1;
        repeat (5) step();
        rd_clk = 0; step();
        chk("hold_one_pop", 96'(level), 96'(lv - 1));
        rd_req = 0; rd_clk = 1; step();
        rd_clk = 0; step();
        chk("no_req_pop", 96'(level), 96'(lv - 1));

        while (mq.size() < 37) wr1(W'($urandom), W'($urandom));
        rx2_en = 1; rx1_valid = 1; step();
        rx1_valid = 1; step();
        sv_ov = m_ov; sv_un = m_un; sv_pe = m_pe;
        chk("pre_flush_level", 96'(level), 96'(37));
        flush = 1; step();
        chk("flush_level", 96'(level), 96'(0));
        chk("flush_empty", 96'(empty), 96'(1));
        chk("flush_ovr", 96'(overrun), 96'(sv_ov));
        chk("flush_udr", 96'(underrun), 96'(sv_un));
        chk("flush_perr", 96'(pair_err), 96'(sv_pe));
        rx2_valid = 1; step();
        chk("flush_dropped_half", 96'(level), 96'(0));

        gap = 0;
        for (int c = 0; c < 6000; c++) begin
            rx1_valid = ($urandom % 6) == 0; rx1_i = W'($urandom); rx1_q = W'($urandom);
            rx2_valid = ($urandom % 6) == 0; rx2_i = W'($urandom); rx2_q = W'($urandom);
            if ($urandom % 300 == 0) rx2_en = ~rx2_en;
            flags_clr = ($urandom % 64) == 0;
            rd_req = ($urandom % 8) != 0;
            if (rd_clk) rd_clk = 0;
            else if (gap <= 0) begin rd_clk = 1; gap = $urandom_range(2, 10); end
            gap--;
            step();
        end

        rd_clk = 0; rx2_en = 0;
        for (int i = 0; i < 3; i++) wr1(W'($urandom), W'($urandom));
        repeat (3) step();
        rd_req = 1; rd_clk = 1;
        #2 reset_n = 0;
        #1;
        chk("rst_head", {RX1_I, RX1_Q, RX2_I, RX2_Q}, 96'(0));
        chk("rst_level", 96'(level), 96'(0));
        chk("rst_empty", 96'(empty), 96'(1));
        chk("rst_flags", 96'({overrun, underrun, pair_err}), 96'(0));
        rd_clk = 0;
        mq.delete(); m_p1 = 0; m_p2 = 0; m_en = 0; m_prev = 0; m_ov = 0; m_un = 0; m_pe = 0;
        @(negedge clk_in) reset_n = 1;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
